// File: rtl/kgp_risc_pkg.sv
// Shared encodings for the PC sequencer: branch opcodes, sequencer states, default PC width.
package kgp_risc_pkg;

    localparam int unsigned DEFAULT_PC_W = 32;

    localparam logic [3:0] BR_NONE = 4'd0;
    localparam logic [3:0] BR_BR   = 4'd1;
    localparam logic [3:0] BR_BZ   = 4'd2;
    localparam logic [3:0] BR_BNZ  = 4'd3;
    localparam logic [3:0] BR_BCY  = 4'd4;
    localparam logic [3:0] BR_BNCY = 4'd5;
    localparam logic [3:0] BR_BS   = 4'd6;
    localparam logic [3:0] BR_BNS  = 4'd7;
    localparam logic [3:0] BR_BV   = 4'd8;
    localparam logic [3:0] BR_BNV  = 4'd9;
    localparam logic [3:0] BR_CALL = 4'd10;
    localparam logic [3:0] BR_RET  = 4'd11;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module return_addr_stack
    import kgp_risc_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = DEFAULT_PC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty,
    output logic         err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [CW-1:0] count;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign top   = mem[ptr - PW'(1)];
    assign err   = (push && full) || (pop && empty);

    // When full, ptr already addresses the oldest entry, so a push overwrites it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (!full) begin
                count <= count + CW'(1);
            end
        end else if (pop && !empty) begin
            ptr   <= ptr - PW'(1);
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, flag-conditional branches, call/ret via RAS, halt/resume.
// Define PC_BOUNDS_CHECK_EN to halt (and flag ras_err) instead of loading a PC >= IMEM_DEPTH.
module pc_sequencer
    import kgp_risc_pkg::*;
#(
    parameter int unsigned     PC_W       = DEFAULT_PC_W,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter int unsigned     RAS_DEPTH  = 8,
    parameter int unsigned     IMEM_DEPTH = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_valid,
    input  logic [3:0]      br_op,
    input  logic [PC_W-1:0] br_target,
    input  logic            flag_c,
    input  logic            flag_z,
    input  logic            flag_s,
    input  logic            flag_v,
    input  logic            halt_req,
    input  logic            resume,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus1,
    output logic            pc_valid,
    output logic            halted,
    output logic            ras_err
);

    function automatic logic cond_taken(input logic [3:0] op, input logic c, input logic z,
                                        input logic s, input logic v);
        case (op)
            BR_BR:   return 1'b1;
            BR_BZ:   return z;
            BR_BNZ:  return !z;
            BR_BCY:  return c;
            BR_BNCY: return !c;
            BR_BS:   return s;
            BR_BNS:  return !s;
            BR_BV:   return v;
            BR_BNV:  return !v;
            default: return 1'b0;
        endcase
    endfunction

    state_e          state;
    logic [PC_W-1:0] next_pc;
    logic [PC_W-1:0] ras_top;
    logic            ras_empty;
    logic            unused_ras_full;
    logic            ras_op_err;
    logic            run_step;
    logic            oob;
    logic            advance;
    logic            ras_push;
    logic            ras_pop;

    assign pc_plus1 = pc + PC_W'(1);

    always_comb begin
        next_pc = pc_plus1;
        if (br_valid) begin
            case (br_op)
                BR_CALL: next_pc = br_target;
                BR_RET:  if (!ras_empty) next_pc = ras_top;
                default: if (cond_taken(br_op, flag_c, flag_z, flag_s, flag_v)) next_pc = br_target;
            endcase
        end
    end

`ifdef PC_BOUNDS_CHECK_EN
    assign oob = (next_pc >= PC_W'(IMEM_DEPTH));
`else
    logic unused_imem_depth;
    assign unused_imem_depth = ^IMEM_DEPTH;
    assign oob = 1'b0;
`endif

    // A RUN cycle that is neither halting nor stalled consumes the branch request.
    assign run_step = (state == ST_RUN) && !halt_req && !stall;
    assign advance  = run_step && !oob;
    assign ras_push = advance && br_valid && (br_op == BR_CALL);
    assign ras_pop  = advance && br_valid && (br_op == BR_RET);

    return_addr_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus1),
        .top       (ras_top),
        .full      (unused_ras_full),
        .empty     (ras_empty),
        .err       (ras_op_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_BOOT;
            pc       <= RESET_PC;
            pc_valid <= 1'b0;
            halted   <= 1'b0;
            ras_err  <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state    <= ST_RUN;
                    pc_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (halt_req || (run_step && oob)) begin
                        state    <= ST_HALT;
                        pc_valid <= 1'b0;
                        halted   <= 1'b1;
                        if (!halt_req) begin
                            ras_err <= 1'b1;
                        end
                    end else if (advance) begin
                        pc <= next_pc;
                        if (ras_op_err) begin
                            ras_err <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        state    <= ST_RUN;
                        pc_valid <= 1'b1;
                        halted   <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_BOOT;
                    pc_valid <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then random traffic vs. a queue-based model.
module tb_pc_sequencer;

    localparam int RAS_DEPTH = 8;
    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic [3:0]  br_op = 4'd0;
    logic [31:0] br_target = '0;
    logic        flag_c = 1'b0;
    logic        flag_z = 1'b0;
    logic        flag_s = 1'b0;
    logic        flag_v = 1'b0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus1;
    logic        pc_valid;
    logic        halted;
    logic        ras_err;

    always #5 clk = ~clk;

    pc_sequencer #(
        .PC_W       (32),
        .RESET_PC   (32'd0),
        .RAS_DEPTH  (RAS_DEPTH),
        .IMEM_DEPTH (1024)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .br_valid  (br_valid),
        .br_op     (br_op),
        .br_target (br_target),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_s    (flag_s),
        .flag_v    (flag_v),
        .halt_req  (halt_req),
        .resume    (resume),
        .pc        (pc),
        .pc_plus1  (pc_plus1),
        .pc_valid  (pc_valid),
        .halted    (halted),
        .ras_err   (ras_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: the RAS is a plain queue of return addresses, newest at the back.
    logic [31:0] m_pc;
    int          m_st;
    logic        m_err;
    logic [31:0] m_ras[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic model_taken(input int op);
        logic f;
        case (op)
            1: return 1'b1;
            2, 3: f = flag_z;
            4, 5: f = flag_c;
            6, 7: f = flag_s;
            8, 9: f = flag_v;
            default: return 1'b0;
        endcase
        // Even opcodes test the flag set, odd opcodes test it clear.
        return (op % 2 == 0) ? f : !f;
    endfunction

    task automatic model_step();
        if (rst) begin
            m_pc  = 32'd0;
            m_st  = M_BOOT;
            m_err = 1'b0;
            m_ras.delete();
        end else if (m_st == M_BOOT) begin
            m_st = M_RUN;
        end else if (m_st == M_HALT) begin
            if (resume) m_st = M_RUN;
        end else if (halt_req) begin
            m_st = M_HALT;
        end else if (!stall) begin
            if (br_valid && br_op == 4'd10) begin
                m_ras.push_back(m_pc + 32'd1);
                if (m_ras.size() > RAS_DEPTH) begin
                    void'(m_ras.pop_front());
                    m_err = 1'b1;
                end
                m_pc = br_target;
            end else if (br_valid && br_op == 4'd11) begin
                if (m_ras.size() == 0) begin
                    m_err = 1'b1;
                    m_pc  = m_pc + 32'd1;
                end else begin
                    m_pc = m_ras.pop_back();
                end
            end else if (br_valid && model_taken(int'(br_op))) begin
                m_pc = br_target;
            end else begin
                m_pc = m_pc + 32'd1;
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic bv, input logic [3:0] op,
                        input logic [31:0] tgt, input logic [3:0] czsv, input logic h,
                        input logic res);
        rst       = r;
        stall     = s;
        br_valid  = bv;
        br_op     = op;
        br_target = tgt;
        {flag_c, flag_z, flag_s, flag_v} = czsv;
        halt_req  = h;
        resume    = res;
        @(posedge clk);
        model_step();
        #1;
        check("pc", pc, m_pc);
        check("pc_plus1", pc_plus1, m_pc + 32'd1);
        check("pc_valid", {31'd0, pc_valid}, {31'd0, m_st == M_RUN});
        check("halted", {31'd0, halted}, {31'd0, m_st == M_HALT});
        check("ras_err", {31'd0, ras_err}, {31'd0, m_err});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 4'd0, 32'd0, 4'b0000, 0, 0);
    endtask

    initial begin
        // Reset and boot: pc=0 invalid, then 0,1,2,3 valid.
        step(1, 0, 0, 4'd0, 32'd0, 4'b0000, 0, 0);
        check("boot_pc_zero", pc, 32'd0);
        idle(4);
        check("run_pc_three", pc, 32'd3);
        // bz taken, then bz not taken.
        step(0, 0, 1, 4'd2, 32'h20, 4'b0100, 0, 0);
        check("bz_taken", pc, 32'h20);
        step(0, 0, 1, 4'd2, 32'h30, 4'b0000, 0, 0);
        check("bz_not_taken", pc, 32'h21);
        // Simple call/ret.
        step(0, 0, 1, 4'd10, 32'h40, 4'b0000, 0, 0);
        idle(2);
        step(0, 0, 1, 4'd11, 32'h0, 4'b0000, 0, 0);
        check("ret_addr", pc, 32'h22);
        // Nine nested calls overflow, nine rets: eight unwind, the last underflows.
        for (int i = 0; i < 9; i++) step(0, 0, 1, 4'd10, 32'h100 + 32'(i * 16), 4'b0000, 0, 0);
        check("overflow_err", {31'd0, ras_err}, 32'd1);
        for (int i = 0; i < 9; i++) step(0, 0, 1, 4'd11, 32'h0, 4'b0000, 0, 0);
        // Stall with a branch pending, then halt and resume.
        for (int i = 0; i < 3; i++) step(0, 1, 1, 4'd1, 32'h77, 4'b0000, 0, 0);
        step(0, 0, 0, 4'd0, 32'h0, 4'b0000, 1, 0);
        idle(2);
        step(0, 0, 0, 4'd0, 32'h0, 4'b0000, 1, 1);
        idle(2);
        // Reset while halted with live RAS entries, then ret must underflow.
        for (int i = 0; i < 3; i++) step(0, 0, 1, 4'd10, 32'h200 + 32'(i), 4'b0000, 0, 0);
        step(0, 0, 0, 4'd0, 32'h0, 4'b0000, 1, 0);
        step(1, 1, 1, 4'd1, 32'h55, 4'b0000, 1, 0);
        idle(1);
        step(0, 0, 1, 4'd11, 32'h0, 4'b0000, 0, 0);
        check("ret_after_reset_err", {31'd0, ras_err}, 32'd1);
        // Wrap of pc+1 at the top of the address space.
        step(0, 0, 1, 4'd1, 32'hFFFF_FFFF, 4'b0000, 0, 0);
        idle(1);
        check("pc_wrap", pc, 32'd0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            logic        r, s, bv, h, res;
            logic [3:0]  op;
            logic [31:0] tgt;
            r   = ($urandom_range(0, 199) == 0);
            s   = ($urandom_range(0, 99) < 15);
            bv  = ($urandom_range(0, 99) < 60);
            op  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) op = ($urandom_range(0, 1) == 0) ? 4'd10 : 4'd11;
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                              : 32'($urandom_range(0, 255));
            h   = ($urandom_range(0, 99) < 3);
            res = ($urandom_range(0, 99) < 30);
            if (m_st == M_BOOT) begin
                s = 1'b0;
                h = 1'b0;
            end
            step(r, s, bv, op, tgt, 4'($urandom_range(0, 15)), h, res);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
